// File: rtl/result_writer.sv
// result_fifo: small synchronous FIFO holding 512-bit result entries, head shown combinationally.
// Latency: an entry pushed in cycle N becomes the head no earlier than cycle N+1 (no bypass).
// Backpressure: push is dropped when full and pop is dropped when empty; the caller must gate on full/empty.
module result_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// result_writer: collects a job's DNN results and writes them to host memory as consecutive 64-byte lines.
// Latency: a result accepted in cycle N is offered on wr_req from N+1; done pulses one cycle after the final ack.
// Backpressure: results_acceptable drops when the FIFO is full or the job count is reached; wr_req holds until wr_ack.
module result_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  base_addr,
    input  logic [31:0]  num_results,
    input  logic         dnn_out_vld,
    input  logic [511:0] dnn_results,
    output logic         results_acceptable,
    output logic         wr_req,
    output logic [63:0]  wr_addr,
    output logic [511:0] wr_data,
    input  logic         wr_ack,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   base_reg;
    logic [31:0]   num_reg;
    logic [31:0]   accepted_cnt;
    logic [31:0]   written_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [511:0]  head_dat;
    logic          start_acc;
    logic          push;
    logic          pop;
    logic          last_write;

    assign start_acc          = (state == IDLE) && start;
    assign results_acceptable = (state == RUN) && !fifo_full && (accepted_cnt < num_reg);
    assign push               = dnn_out_vld && results_acceptable;
    assign wr_req             = (state == RUN) && !fifo_empty;
    assign pop                = wr_req && wr_ack;
    assign last_write         = ((written_cnt + 32'd1) == num_reg);

    // Line address is a shift of the write count; the 64-bit add wraps silently.
    assign wr_addr = base_reg + {26'd0, written_cnt, 6'd0};
    // Masking keeps wr_data at zero whenever nothing is offered, including during reset.
    assign wr_data = wr_req ? head_dat : '0;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    result_fifo #(
        .W     (512),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (dnn_results),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_results == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                if (pop && last_write) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg     <= '0;
            num_reg      <= '0;
            accepted_cnt <= '0;
            written_cnt  <= '0;
        end else if (start_acc) begin
            base_reg     <= {base_addr[63:6], 6'd0};
            num_reg      <= num_results;
            accepted_cnt <= '0;
            written_cnt  <= '0;
        end else begin
            if (push) accepted_cnt <= accepted_cnt + 32'd1;
            if (pop)  written_cnt  <= written_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_result_writer.sv
// Randomized bench for result_writer with a queue-based model of the job/write behaviour.
module tb_result_writer;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  base_addr = '0;
    logic [31:0]  num_results = '0;
    logic         dnn_out_vld = 1'b0;
    logic [511:0] dnn_results = '0;
    logic         results_acceptable;
    logic         wr_req;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ack = 1'b0;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    result_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .base_addr          (base_addr),
        .num_results        (num_results),
        .dnn_out_vld        (dnn_out_vld),
        .dnn_results        (dnn_results),
        .results_acceptable (results_acceptable),
        .wr_req             (wr_req),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_ack             (wr_ack),
        .busy               (busy),
        .done               (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: 0 = idle, 1 = running, 2 = completion cycle
    int           m_st = 0;
    logic [63:0]  m_base = '0;
    int unsigned  m_num = 0;
    int unsigned  m_acc = 0;
    int unsigned  m_wr = 0;
    logic [511:0] m_q[$];
    logic [63:0]  wlog[$];
    int           dut_push_cnt = 0;

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic step(input logic s, input logic [63:0] b, input logic [31:0] n,
                        input logic v, input logic a);
        logic        exp_ra;
        logic        exp_req;
        logic        do_push;
        logic        do_pop;
        logic [63:0] exp_addr;
        start       = s;
        base_addr   = b;
        num_results = n;
        dnn_out_vld = v;
        dnn_results = rand512();
        wr_ack      = a;
        @(negedge clk);
        exp_ra   = (m_st == 1) && (m_q.size() < DEPTH) && (m_acc < m_num);
        exp_req  = (m_st == 1) && (m_q.size() != 0);
        exp_addr = m_base + 64'(m_wr) * 64'd64;
        chk("busy", busy, m_st != 0);
        chk("done", done, m_st == 2);
        chk("results_acceptable", results_acceptable, exp_ra);
        chk("wr_req", wr_req, exp_req);
        if (exp_req) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, m_q[0]);
        end
        if (results_acceptable && v) dut_push_cnt++;
        do_push = v && exp_ra;
        do_pop  = exp_req && a;
        @(posedge clk);
        #1;
        case (m_st)
            0: if (s) begin
                m_base = {b[63:6], 6'd0};
                m_num  = n;
                m_acc  = 0;
                m_wr   = 0;
                m_st   = (n == 0) ? 2 : 1;
            end
            1: begin
                if (do_pop) begin
                    void'(m_q.pop_front());
                    wlog.push_back(exp_addr);
                    m_wr++;
                end
                if (do_push) begin
                    m_q.push_back(dnn_results);
                    m_acc++;
                end
                if (do_pop && m_wr == m_num) m_st = 2;
            end
            default: m_st = 0;
        endcase
    endtask

    // Runs until the model is idle again, with random valid/ack and stray start pulses.
    task automatic run_job(input int vld_pct, input int ack_pct, input int bound);
        int k = 0;
        while (m_st != 0 && k < bound) begin
            step(($urandom_range(7) == 0), rand64(), $urandom,
                 ($urandom_range(99) < vld_pct), ($urandom_range(99) < ack_pct));
            k++;
        end
        if (m_st != 0) chk("job_timeout", 1'b1, 1'b0);
    endtask

    task automatic begin_job(input logic [63:0] b, input logic [31:0] n);
        wlog.delete();
        step(1'b1, b, n, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ra", results_acceptable, 1'b0);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_wr_addr", wr_addr, 64'd0);
        chk("rst_wr_data", wr_data, 512'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Results offered while idle, plus stray acks, must be ignored.
        dut_push_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b0, rand64(), $urandom, 1'b1, 1'b1);
        chk("idle_pushes", dut_push_cnt, 0);

        // Three results, ack always high.
        begin_job(64'h1000, 32'd3);
        run_job(100, 100, 50);
        chk("basic_count", wlog.size(), 3);
        chk("basic_a0", wlog[0], 64'h1000);
        chk("basic_a1", wlog[1], 64'h1040);
        chk("basic_a2", wlog[2], 64'h1080);
        step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
        chk("basic_idle_busy", busy, 1'b0);

        // Host stall: FIFO fills after DEPTH pushes, write request holds steady.
        begin_job(rand64(), 32'd8);
        dut_push_cnt = 0;
        for (int i = 0; i < 20; i++) step(1'b0, rand64(), $urandom, 1'b1, 1'b0);
        chk("stall_pushes", dut_push_cnt, DEPTH);
        run_job(100, 100, 100);
        chk("stall_count", wlog.size(), 8);

        // Empty job completes immediately.
        begin_job(rand64(), 32'd0);
        run_job(100, 100, 10);
        chk("zero_count", wlog.size(), 0);

        // Reset mid-job after two writes.
        begin_job(rand64(), 32'd5);
        for (int i = 0; i < 40 && wlog.size() < 2; i++) step(1'b0, rand64(), $urandom, 1'b1, 1'b1);
        chk("pre_reset_writes", wlog.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ra", results_acceptable, 1'b0);
        chk("mid_rst_wr_req", wr_req, 1'b0);
        chk("mid_rst_wr_addr", wr_addr, 64'd0);
        chk("mid_rst_wr_data", wr_data, 512'd0);
        m_st = 0;
        m_base = '0;
        m_wr = 0;
        m_acc = 0;
        m_num = 0;
        m_q.delete();
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin_job(64'h2000, 32'd2);
        run_job(80, 80, 60);
        chk("post_rst_count", wlog.size(), 2);
        chk("post_rst_a0", wlog[0], 64'h2000);
        chk("post_rst_a1", wlog[1], 64'h2040);

        // Unaligned base and address wrap.
        begin_job(64'h1025, 32'd1);
        run_job(100, 100, 20);
        chk("align_count", wlog.size(), 1);
        chk("align_a0", wlog[0], 64'h1000);
        begin_job(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
        run_job(100, 100, 20);
        chk("wrap_count", wlog.size(), 2);
        chk("wrap_a0", wlog[0], 64'hFFFF_FFFF_FFFF_FFC0);
        chk("wrap_a1", wlog[1], 64'h0);

        // Random jobs with random flow control on both sides.
        for (int j = 0; j < 15; j++) begin
            int unsigned n;
            n = $urandom_range(12);
            begin_job(rand64(), n);
            run_job($urandom_range(100, 20), $urandom_range(100, 20), 400);
            chk("rand_count", wlog.size(), n);
            for (int i = 0; i < $urandom_range(3); i++)
                step(1'b0, rand64(), $urandom, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
